// File: rtl/ft245_fifo_responder_if.sv
// FT245-style bus (nRD/WR/D/nRXF/nTXE) plus host byte streams.
// slave: responder side; master: bus master and host side.
interface ft245_fifo_responder_if;
  logic       nRD;
  logic       WR;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic       nRXF;
  logic       nTXE;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rd_err;
  logic       wr_err;

  modport slave (
    input  nRD, WR, D_IN,
    input  rx_data, rx_valid, tx_ready,
    output D_OUT, D_OE, nRXF, nTXE,
    output rx_ready, tx_data, tx_valid,
    output rd_err, wr_err
  );

  modport master (
    output nRD, WR, D_IN,
    output rx_data, rx_valid, tx_ready,
    input  D_OUT, D_OE, nRXF, nTXE,
    input  rx_ready, tx_data, tx_valid,
    input  rd_err, wr_err
  );
endinterface

// File: rtl/ft245_fifo_responder.sv
// FT245 FIFO-bus device model: RX FIFO (host->master), TX FIFO (master->host).
// Ports: CLK, nRST_ASYNC, bus (slave modport). FT245_RESP_SYNC_EN adds 2-flop strobe sync.
module ft245_fifo_responder #(
  parameter int DEPTH     = 16,
  parameter int PRECHARGE = 2
) (
  input logic                   CLK,
  input logic                   nRST_ASYNC,
  ft245_fifo_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PRECHARGE + 1);
  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_PRE} rd_st_t;
  typedef enum logic {W_IDLE, W_PRE} wr_st_t;

  logic       w_rd_pin;
  logic       w_wr_pin;
  logic [7:0] w_din_pin;

`ifdef FT245_RESP_SYNC_EN
  logic [1:0] r_rd_sync;
  logic [1:0] r_wr_sync;
  logic [7:0] r_din_q1;
  logic [7:0] r_din_q2;

  // D_IN travels with WR so the byte lines up with the edge
  always_ff @(posedge CLK or negedge nRST_ASYNC) begin
    if (!nRST_ASYNC) begin
      r_rd_sync <= 2'b11;
      r_wr_sync <= 2'b00;
      r_din_q1  <= '0;
      r_din_q2  <= '0;
    end else begin
      r_rd_sync <= {r_rd_sync[0], bus.nRD};
      r_wr_sync <= {r_wr_sync[0], bus.WR};
      r_din_q1  <= bus.D_IN;
      r_din_q2  <= r_din_q1;
    end
  end

  assign w_rd_pin  = r_rd_sync[1];
  assign w_wr_pin  = r_wr_sync[1];
  assign w_din_pin = r_din_q2;
`else
  assign w_rd_pin  = bus.nRD;
  assign w_wr_pin  = bus.WR;
  assign w_din_pin = bus.D_IN;
`endif

  logic       r_s_rd;
  logic       r_p_rd;
  logic       r_s_wr;
  logic       r_p_wr;
  logic [7:0] r_s_din;

  always_ff @(posedge CLK or negedge nRST_ASYNC) begin
    if (!nRST_ASYNC) begin
      r_s_rd  <= 1'b1;
      r_p_rd  <= 1'b1;
      r_s_wr  <= 1'b0;
      r_p_wr  <= 1'b0;
      r_s_din <= '0;
    end else begin
      r_s_rd  <= w_rd_pin;
      r_p_rd  <= r_s_rd;
      r_s_wr  <= w_wr_pin;
      r_p_wr  <= r_s_wr;
      r_s_din <= w_din_pin;
    end
  end

  logic w_rd_fall;
  logic w_rd_rise;
  logic w_wr_fall;
  assign w_rd_fall = r_p_rd & ~r_s_rd;
  assign w_rd_rise = ~r_p_rd & r_s_rd;
  assign w_wr_fall = r_p_wr & ~r_s_wr;

  logic [7:0] r_rx_mem [DEPTH];
  logic [7:0] r_tx_mem [DEPTH];
  ptr_t       r_rx_wp, r_rx_rp;
  ptr_t       r_tx_wp, r_tx_rp;
  rd_st_t     r_rst;
  wr_st_t     r_wst;
  logic       r_nrxf;
  logic       r_ntxe;

  logic w_rx_full, w_tx_empty, w_tx_full;
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW])
                   && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW])
                   && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_tx_empty = (r_tx_wp == r_tx_rp);

  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic w_rd_go;
  assign w_rd_go   = w_rd_fall & ~r_nrxf;
  assign w_rx_push = bus.rx_valid & ~w_rx_full;
  assign w_rx_pop  = (r_rst == R_ACTIVE) & w_rd_rise;
  assign w_tx_push = w_wr_fall & ~r_ntxe;
  assign w_tx_pop  = ~w_tx_empty & bus.tx_ready;

  // next-cycle pointers let nRXF/nTXE be registered yet track the FIFO
  ptr_t w_rx_wp_n, w_rx_rp_n, w_tx_wp_n, w_tx_rp_n;
  logic w_rx_empty_n, w_tx_full_n;
  assign w_rx_wp_n    = r_rx_wp + ptr_t'(w_rx_push);
  assign w_rx_rp_n    = r_rx_rp + ptr_t'(w_rx_pop);
  assign w_tx_wp_n    = r_tx_wp + ptr_t'(w_tx_push);
  assign w_tx_rp_n    = r_tx_rp + ptr_t'(w_tx_pop);
  assign w_rx_empty_n = (w_rx_wp_n == w_rx_rp_n);
  assign w_tx_full_n  = (w_tx_wp_n[AW] != w_tx_rp_n[AW])
                     && (w_tx_wp_n[AW-1:0] == w_tx_rp_n[AW-1:0]);

  always_ff @(posedge CLK) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= bus.rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= r_s_din;
  end

  always_ff @(posedge CLK or negedge nRST_ASYNC) begin
    if (!nRST_ASYNC) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      r_rx_wp <= w_rx_wp_n;
      r_rx_rp <= w_rx_rp_n;
      r_tx_wp <= w_tx_wp_n;
      r_tx_rp <= w_tx_rp_n;
    end
  end

  logic [CW-1:0] r_rcnt;
  logic          r_doe;
  logic [7:0]    r_dout;
  logic          r_rd_err;

  always_ff @(posedge CLK or negedge nRST_ASYNC) begin
    if (!nRST_ASYNC) begin
      r_rst    <= R_IDLE;
      r_rcnt   <= '0;
      r_nrxf   <= 1'b1;
      r_doe    <= 1'b0;
      r_dout   <= '0;
      r_rd_err <= 1'b0;
    end else begin
      r_rd_err <= w_rd_fall & r_nrxf;
      unique case (r_rst)
        R_IDLE: begin
          if (w_rd_go) begin
            r_rst  <= R_ACTIVE;
            r_doe  <= 1'b1;
            r_dout <= r_rx_mem[r_rx_rp[AW-1:0]];
            r_nrxf <= 1'b1;
          end else begin
            r_nrxf <= w_rx_empty_n;
          end
        end
        R_ACTIVE: begin
          if (w_rd_rise) begin
            r_rst  <= R_PRE;
            r_doe  <= 1'b0;
            r_rcnt <= CW'(PRECHARGE);
          end
        end
        R_PRE: begin
          r_rcnt <= r_rcnt - CW'(1);
          if (r_rcnt == CW'(1)) begin
            r_rst  <= R_IDLE;
            r_nrxf <= w_rx_empty_n;
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  logic [CW-1:0] r_wcnt;
  logic          r_wr_err;

  always_ff @(posedge CLK or negedge nRST_ASYNC) begin
    if (!nRST_ASYNC) begin
      r_wst    <= W_IDLE;
      r_wcnt   <= '0;
      r_ntxe   <= 1'b1;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_fall & r_ntxe;
      unique case (r_wst)
        W_IDLE: begin
          if (w_tx_push) begin
            r_wst  <= W_PRE;
            r_wcnt <= CW'(PRECHARGE);
            r_ntxe <= 1'b1;
          end else begin
            r_ntxe <= w_tx_full_n;
          end
        end
        W_PRE: begin
          r_wcnt <= r_wcnt - CW'(1);
          if (r_wcnt == CW'(1)) begin
            r_wst  <= W_IDLE;
            r_ntxe <= w_tx_full_n;
          end
        end
      endcase
    end
  end

  assign bus.D_OUT    = r_dout;
  assign bus.D_OE     = r_doe;
  assign bus.nRXF     = r_nrxf;
  assign bus.nTXE     = r_ntxe;
  assign bus.rd_err   = r_rd_err;
  assign bus.wr_err   = r_wr_err;
  assign bus.rx_ready = ~w_rx_full;
  assign bus.tx_valid = ~w_tx_empty;
  assign bus.tx_data  = w_tx_empty ? 8'h00
                      : r_tx_mem[r_tx_rp[AW-1:0]];
endmodule

// File: doc/ft245_fifo_responder.md
# ft245_fifo_responder

Device-side model of the FT245-style asynchronous FIFO bus: the counterpart of the blaster handler, which acts as bus master through nRXF/nTXE/nRD/WR/D. The block owns two byte FIFOs. Bytes pushed on its host stream become readable by the master. Bytes the master writes appear on its output stream. It is used for on-chip loopback of the blaster logic and as the bus-functional responder in its benches.

## Interface
- DEPTH, 16: entries per FIFO; power of two, ≥ 2.
- PRECHARGE, 2: cycles nRXF/nTXE are held inactive after each completed transfer; ≥ 1.
- CLK  in  1  single clock for all logic.
- nRST_ASYNC  in  1  reset, asynchronous assert, active-low; release is synchronous to CLK, from the existing reset block.
- nRD  in  1  master read strobe, active-low.
- WR  in  1  master write strobe; data is latched on the falling edge.
- D_IN  in  8  bus data from the master.
- D_OUT  out  8  bus data to the master.
- D_OE  out  1  D_OUT drive enable; the top level builds the tristate.
- nRXF  out  1  low = readable byte available.
- nTXE  out  1  low = space for a master write.
- rx_data  in  8  host byte toward the master.
- rx_valid  in  1  host push request.
- rx_ready  out  1  RX FIFO not full.
- tx_data  out  8  byte written by the master.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  host pop acknowledge.
- rd_err  out  1  one-cycle pulse on a protocol-violating read.
- wr_err  out  1  one-cycle pulse on a protocol-violating write.

## Operation
- RX FIFO: a push occurs when rx_valid && rx_ready. rx_ready = !full, taken from registered state. On a full FIFO, a push is refused even if a pop happens in the same cycle.
- TX FIFO: a pop occurs when tx_valid && tx_ready. tx_data = head, valid while tx_valid is high.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full = MSBs differ and low bits are equal.
  - empty = pointers are equal.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
- Strobe sampling: nRD and WR are registered once (s_rd, s_wr). Edges are detected against the previous sample.
- Read FSM states: R_IDLE, R_ACTIVE, R_PRE.
  - R_IDLE: nRXF = empty. A falling nRD edge with nRXF low moves to R_ACTIVE and sets D_OE=1 and D_OUT=RX head.
  - A falling nRD edge with nRXF high gives one rd_err pulse. There is no drive and no pop.
  - R_ACTIVE: nRXF=1 and D_OUT is held. A rising nRD edge pops the RX FIFO, clears D_OE, loads the precharge counter with PRECHARGE, and moves to R_PRE.
  - R_PRE: nRXF=1. The counter decrements each cycle. At 0 the FSM moves to R_IDLE.
- Write FSM states: W_IDLE, W_PRE.
  - W_IDLE: nTXE = full. A falling WR edge with nTXE low writes D_IN into the TX FIFO. This is the registered D_IN sampled in the same cycle as the edge. The FSM then moves to W_PRE with nTXE=1 for PRECHARGE cycles.
  - A falling WR edge with nTXE high gives one wr_err pulse and drops the byte.
- The read and write FSMs are independent. Simultaneous read and write transfers are both honoured.
- Reset, including mid-transfer: both FIFOs flush, FSMs go to idle, and the counters clear.

## Timing
- Reset values: nRXF=1, nTXE=1, D_OE=0, D_OUT=0x00, rx_ready=1, tx_valid=0, tx_data=0x00, rd_err=0, wr_err=0.
- Push on RX (cycle n) → nRXF low at n+1 if the FIFO was empty and the read FSM is idle.
- nRD low at the pin (cycle n) → D_OE=1 with valid D_OUT at n+2: one sample cycle plus one registered output.
- nRD high at the pin (cycle n) → D_OE=0 and nRXF=1 at n+2. nRXF may fall again no earlier than n+2+PRECHARGE.
- WR falling at the pin (cycle n) → tx_valid=1 at n+2 if the FIFO was empty. nTXE=1 from n+2 for PRECHARGE cycles.
- Outputs are registered with no combinational path from inputs, except rx_ready and tx_data/tx_valid, which come from FIFO state flops.

## Configuration
- FT245_RESP_SYNC_EN defined: nRD and WR each pass through a two-flop synchronizer ahead of the sample register. D_IN is registered alongside them. All pin-to-response latencies grow by 2 cycles. Use this when the master runs on an unrelated clock.
- FT245_RESP_SYNC_EN undefined: the single sample register only. The master must be synchronous to CLK.

## Test plan
- Push 0xA5, 0x3C on the host side; perform two master reads with nRD low for 4 cycles → D_OUT shows 0xA5 then 0x3C. nRXF stays high for exactly PRECHARGE cycles after each read, then returns to 1 once the FIFO is empty.
- Master writes 0x11, 0x22, 0x33 with tx_ready=0 → tx_valid=1, tx_data=0x11. Asserting tx_ready pops them in order, and tx_valid falls after 0x33.
- Fill the TX FIFO with DEPTH writes → nTXE stays 1. A 17th WR edge gives one wr_err pulse and the level stays 16.
- nRD pulse with the RX FIFO empty → one rd_err pulse, D_OE stays 0, and no pointer changes.
- RX FIFO full, rx_valid=1 during a master read pop → the push is refused that cycle and accepted the following cycle. The level returns to 16.
- Assert nRST_ASYNC while nRD is low in R_ACTIVE with 3 bytes queued → D_OE=0 and nRXF=1 immediately. After release, the FIFOs are empty and rx_ready=1.
